// File: rtl/fpnew_rob_pkg.sv
// Shared types for the fpnew reorder-buffer front end.
// status_t mirrors the fpnew_pkg::status_t layout, so flags pass through unchanged.
package fpnew_rob_pkg;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  localparam int unsigned STATUS_W = $bits(status_t);

endpackage

// File: rtl/fpnew_rob_if.sv
// Core-side and fpnew-side handshakes of the reorder buffer, bundled together.
// The master modport is the ROB itself; the slave modport is the core plus fpnew.
interface fpnew_rob_if
  import fpnew_rob_pkg::*;
#(
  parameter int unsigned Width    = 64,
  parameter int unsigned TagWidth = 2
) ();

  logic                req_valid_i;
  logic                req_ready_o;
  logic                fpu_in_valid_o;
  logic                fpu_in_ready_i;
  logic [TagWidth-1:0] fpu_tag_o;
  logic                fpu_out_valid_i;
  logic                fpu_out_ready_o;
  logic [Width-1:0]    fpu_result_i;
  status_t             fpu_status_i;
  logic [TagWidth-1:0] fpu_tag_i;
  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic [Width-1:0]    rsp_result_o;
  status_t             rsp_status_o;
  logic                busy_o;

  modport master (
    input  req_valid_i, fpu_in_ready_i, fpu_out_valid_i, fpu_result_i, fpu_status_i,
           fpu_tag_i, rsp_ready_i,
    output req_ready_o, fpu_in_valid_o, fpu_tag_o, fpu_out_ready_o, rsp_valid_o,
           rsp_result_o, rsp_status_o, busy_o
  );

  modport slave (
    output req_valid_i, fpu_in_ready_i, fpu_out_valid_i, fpu_result_i, fpu_status_i,
           fpu_tag_i, rsp_ready_i,
    input  req_ready_o, fpu_in_valid_o, fpu_tag_o, fpu_out_ready_o, rsp_valid_o,
           rsp_result_o, rsp_status_o, busy_o
  );

endinterface

// File: rtl/fpnew_rob_ptr.sv
// Wrapping slot pointer: advances on inc_i, returns to zero on clr_i.
// Wrap-around is free because the slot count is a power of two.
module fpnew_rob_ptr #(
  parameter int unsigned PtrWidth = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                inc_i,
  output logic [PtrWidth-1:0] ptr_o
);

  logic [PtrWidth-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + PtrWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fpnew_rob.sv
// Issue/retire front end for fpnew_top: tags each issued op with its slot index and
// retires out-of-order fpnew results to the core strictly in issue order.
module fpnew_rob
  import fpnew_rob_pkg::*;
#(
  parameter int unsigned Width    = 64,
  parameter int unsigned Depth    = 4,
  parameter int unsigned TagWidth = $clog2(Depth)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  fpnew_rob_if.master  bus
);

  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef struct packed {
    logic             done;
    logic [Width-1:0] result;
    status_t          status;
  } rob_slot_t;

  rob_slot_t           slot_d [Depth];
  rob_slot_t           slot_q [Depth];
  logic [CntW-1:0]     cnt_d, cnt_q;
  logic                stale_ok_d, stale_ok_q;
  logic [TagWidth-1:0] alloc_q, head_q;
  logic [TagWidth-1:0] tag_offset;
  logic                full, issue, retire, tag_live, result_wr;

  assign full       = (cnt_q == CntW'(Depth));
  assign issue      = bus.fpu_in_valid_o & bus.fpu_in_ready_i;
  assign retire     = bus.rsp_valid_o & bus.rsp_ready_i & ~flush_i;
  // A tag is live when it lies in the window [head, head + cnt) modulo Depth.
  assign tag_offset = bus.fpu_tag_i - head_q;
  assign tag_live   = (CntW'(tag_offset) < cnt_q);
  assign result_wr  = bus.fpu_out_valid_i & tag_live & ~flush_i;

  fpnew_rob_ptr #(.PtrWidth(TagWidth)) u_alloc_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (flush_i),
    .inc_i  (issue),
    .ptr_o  (alloc_q)
  );

  fpnew_rob_ptr #(.PtrWidth(TagWidth)) u_head_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (flush_i),
    .inc_i  (retire),
    .ptr_o  (head_q)
  );

  always_comb begin
    cnt_d      = cnt_q;
    stale_ok_d = stale_ok_q;
    for (int i = 0; i < Depth; i++) begin
      slot_d[i] = slot_q[i];
    end
    if (flush_i) begin
      cnt_d      = '0;
      stale_ok_d = 1'b1;
      for (int i = 0; i < Depth; i++) begin
        slot_d[i].done = 1'b0;
      end
    end else begin
      if (issue && !retire) begin
        cnt_d = cnt_q + CntW'(1);
      end else if (retire && !issue) begin
        cnt_d = cnt_q - CntW'(1);
      end
      if (issue) begin
        slot_d[alloc_q].done = 1'b0;
        stale_ok_d           = 1'b0;
      end
      if (result_wr) begin
        slot_d[bus.fpu_tag_i].done   = 1'b1;
        slot_d[bus.fpu_tag_i].result = bus.fpu_result_i;
        slot_d[bus.fpu_tag_i].status = bus.fpu_status_i;
      end
      if (retire) begin
        slot_d[head_q].done = 1'b0;
      end
    end
  end

  // Result storage is cleared on reset so the retire port idles at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        slot_q[i] <= '0;
      end
      cnt_q      <= '0;
      stale_ok_q <= 1'b1;
    end else begin
      slot_q     <= slot_d;
      cnt_q      <= cnt_d;
      stale_ok_q <= stale_ok_d;
    end
  end

  assign bus.fpu_in_valid_o  = bus.req_valid_i & ~full & ~flush_i;
  assign bus.req_ready_o     = issue;
  assign bus.fpu_tag_o       = alloc_q;
  assign bus.fpu_out_ready_o = 1'b1;
  assign bus.rsp_valid_o     = slot_q[head_q].done & (cnt_q != '0);
  assign bus.rsp_result_o    = slot_q[head_q].result;
  assign bus.rsp_status_o    = slot_q[head_q].status;
  assign bus.busy_o          = (cnt_q != '0);

  // Stragglers from a flushed or reset epoch may still drain out of fpnew until
  // the next issue, so stale tags are only flagged once a new epoch has started.
  a_result_tag_live : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (bus.fpu_out_valid_i && !flush_i && !stale_ok_q) |-> tag_live
  ) else $error("fpnew_rob: result tag %0d does not name an allocated slot", bus.fpu_tag_i);

endmodule
